// File: rtl/sched_pkg.sv
// Shared definitions for the port scheduler: FSM encoding, mode constants and
// an index-width helper.
package sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic MODE_SP  = 1'b0;
  localparam logic MODE_WRR = 1'b1;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-set search: first asserted bit at or after ptr, wrapping at N.
module rr_pick
  import sched_pkg::*;
#(
  parameter  int N  = 16,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin : pick
    int pos;
    pos    = 0;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/port_scheduler.sv
// Packet-granular ingress scheduler, strict priority or weighted round robin.
// Optional stall watchdog enabled by defining SCHED_TIMEOUT_EN.
module port_scheduler
  import sched_pkg::*;
#(
  parameter  int NUM_PORTS   = 16,
  parameter  int WEIGHT_W    = 4,
  parameter  int TIMEOUT_CYC = 256,
  localparam int IW          = idx_w(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sp0_wrr1,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          last,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_p,
  input  logic                          sram_ready,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic                          gnt_valid,
  output logic [IW-1:0]                 gnt_id,
  output logic                          timeout_err
);

  typedef logic [NUM_PORTS-1:0][WEIGHT_W-1:0] cred_t;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]        id_q, id_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 mode_q, mode_d;
  cred_t                cred_q, cred_d;

  cred_t                reload, cred_base, cred_arb;
  logic [NUM_PORTS-1:0] has_cred, elig, pick_req, pick_oh;
  logic [IW-1:0]        pick_ptr, pick_idx;
  logic                 pick_found, need_reload, mode_switch, to_hit;
  logic [WEIGHT_W-1:0]  cred_left;

  // Reload values with weight 0 promoted to 1 so every port keeps a turn.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_reload
    assign reload[i] = (weight_p[i*WEIGHT_W +: WEIGHT_W] == '0) ? WEIGHT_W'(1)
                                                               : weight_p[i*WEIGHT_W +: WEIGHT_W];
  end

  assign mode_switch = (state_q == ST_IDLE) && (sp0_wrr1 == MODE_WRR) && (mode_q == MODE_SP);

  // Credit view used for this cycle's arbitration, refilled when nobody eligible.
  always_comb begin
    has_cred  = '0;
    cred_base = mode_switch ? reload : cred_q;
    for (int i = 0; i < NUM_PORTS; i++) has_cred[i] = (cred_base[i] != '0);
    need_reload = (|req) && !(|(req & has_cred));
    cred_arb    = need_reload ? reload : cred_base;
    elig        = need_reload ? req : (req & has_cred);
  end

  assign pick_req = (sp0_wrr1 == MODE_WRR) ? elig : req;
  assign pick_ptr = ((sp0_wrr1 == MODE_WRR) && !mode_switch) ? ptr_q : '0;

  rr_pick #(.N(NUM_PORTS)) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] stall_q, stall_d;
  logic          to_q;

  always_comb begin
    stall_d = '0;
    to_hit  = 1'b0;
    if ((state_q == ST_BUSY) && !sram_ready) begin
      if (stall_q == CW'(TIMEOUT_CYC - 1)) to_hit = 1'b1;
      else                                 stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      to_q    <= 1'b0;
    end else begin
      stall_q <= stall_d;
      to_q    <= to_hit;
    end
  end

  assign timeout_err = to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign to_hit             = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    mode_d    = mode_q;
    cred_d    = cred_q;
    cred_left = '0;
    case (state_q)
      ST_IDLE: begin
        mode_d = sp0_wrr1;
        gnt_d  = '0;
        id_d   = '0;
        if (mode_switch) begin
          cred_d = reload;
          ptr_d  = '0;
        end
        if (pick_found) begin
          state_d = ST_BUSY;
          gnt_d   = pick_oh;
          id_d    = pick_idx;
          if (sp0_wrr1 == MODE_WRR) cred_d = cred_arb;
        end
      end
      ST_BUSY: begin
        // Packet ends on its last beat or when the watchdog forces release.
        if ((sram_ready && last[id_q]) || to_hit) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          id_d    = '0;
          if (mode_q == MODE_WRR) begin
            cred_left      = cred_q[id_q] - 1'b1;
            cred_d[id_q]   = cred_left;
            ptr_d          = (cred_left != '0) ? id_q :
                             ((id_q == IW'(NUM_PORTS - 1)) ? '0 : id_q + 1'b1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      mode_q  <= MODE_SP;
      cred_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      cred_q  <= cred_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = (state_q == ST_BUSY);

endmodule

// File: doc/port_scheduler.md
PORT_SCHEDULER -- requirements
Module: port_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 16, number of requesting ingress ports.
REQ-002 SHALL have parameter WEIGHT_W, default 4, width of each per-port WRR weight.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 256, stall limit used only under REQ-027.
REQ-004 SHALL have clk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have sp0_wrr1  input  1  mode select: 0 = strict priority, 1 = weighted round robin.
REQ-007 SHALL have req  input  NUM_PORTS  per-port request, level, held until the port's packet is granted.
REQ-008 SHALL have last  input  NUM_PORTS  per-port end-of-packet flag for the current beat.
REQ-009 SHALL have weight_p  input  NUM_PORTS*WEIGHT_W  packed weights, port i at bits [i*WEIGHT_W +: WEIGHT_W].
REQ-010 SHALL have sram_ready  input  1  SRAM write port accepts a beat this cycle.
REQ-011 SHALL have gnt  output  NUM_PORTS  one-hot grant, registered.
REQ-012 SHALL have gnt_valid  output  1  gnt is active, registered.
REQ-013 SHALL have gnt_id  output  clog2(NUM_PORTS)  binary index of granted port, registered.
REQ-014 SHALL have timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY; beat transfer = gnt_valid & sram_ready.
REQ-016 IDLE: if any req bit set, SHALL compute winner combinationally and register gnt/gnt_id/gnt_valid=1, entering BUSY next cycle (1-cycle req-to-grant latency); no req: stay IDLE, outputs 0.
REQ-017 BUSY: grant SHALL be held constant regardless of req/sp0_wrr1 changes until a transfer with last[gnt_id]=1.
REQ-018 On that final transfer SHALL drop gnt_valid/gnt next cycle and return to IDLE (one idle bubble between packets).
REQ-019 SP mode: winner SHALL be the lowest-index port with req=1.
REQ-020 WRR mode: each port SHALL own a credit counter (WEIGHT_W bits); winner = first port at or after rr_ptr (wrapping NUM_PORTS-1 -> 0) with req=1 and credit>0.
REQ-021 WRR: if requests exist but no requesting port has credit, SHALL reload all credits from weight_p and arbitrate on reloaded values in the same cycle.
REQ-022 Weight 0 SHALL be treated as 1.
REQ-023 WRR: on packet completion SHALL decrement winner credit; rr_ptr = winner if remaining credit>0, else winner+1 modulo NUM_PORTS.
REQ-024 sp0_wrr1 SHALL be sampled only in IDLE; a 0->1 change SHALL reload all credits and reset rr_ptr to 0 before arbitration.

Reset
REQ-025 rst SHALL force IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout_err=0, rr_ptr=0, credits=0 (reloaded at first WRR arbitration).
REQ-026 rst mid-packet SHALL drop the grant next cycle with no completion side effects.

Configuration
REQ-027 With SCHED_TIMEOUT_EN defined: a counter SHALL count BUSY cycles without a transfer, clear on every transfer, and on reaching TIMEOUT_CYC force return to IDLE, pulse timeout_err, and treat the packet as completed for WRR accounting.
REQ-028 Without SCHED_TIMEOUT_EN: no counter synthesized, timeout_err tied to 0, BUSY held indefinitely.

Structure
REQ-029 Shared package sched_pkg SHALL hold the FSM state encoding and mode constants MODE_SP=0, MODE_WRR=1.
REQ-030 Sub-module rr_pick SHALL implement the rotating first-set search (request vector, start pointer -> one-hot, index, found); SP mode uses it with pointer 0.

Verification
REQ-031 SP: req=0x0006, 2-beat packets, sram_ready=1 -> port 1 granted cycle after req, port 2 granted after port 1's last plus one bubble.
REQ-032 WRR: all 16 req, weights port0=2, others=1, 1-beat packets -> grant order 0,0,1,2,...,15, then reload and repeat.
REQ-033 Backpressure: sram_ready=0 for 5 cycles mid-packet -> gnt_id unchanged, no timeout, packet completes when ready returns.
REQ-034 Mode switch during BUSY: sp0_wrr1 toggled mid-packet -> current grant unaffected; new mode applies at next IDLE arbitration.
REQ-035 SCHED_TIMEOUT_EN, TIMEOUT_CYC=8, sram_ready=0 held -> timeout_err pulses after 8 stalled cycles, gnt_valid=0 next cycle.
REQ-036 rst asserted in BUSY -> all outputs 0 next cycle; next SP arbitration picks lowest requester.
